// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared VGA timing defaults, decoder state encoding, delay-line
//                tap type and sync-window helper.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_h_vis   = 640;
    localparam int c_h_fp    = 16;
    localparam int c_h_sync  = 96;
    localparam int c_h_bp    = 48;
    localparam int c_v_vis   = 480;
    localparam int c_v_fp    = 10;
    localparam int c_v_sync  = 2;
    localparam int c_v_bp    = 33;
    localparam int c_rgb_lag = 1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One entry of the coordinate delay line
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
    } pos_tap_t;

    // True when pos lies in [lo, lo+len-1]
    function automatic logic in_window(input logic [9:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pos_counter
//  Description : Raster x/y counter with line/frame wrap. Exposes the position
//                after the next advance and the sync levels expected there.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_pos_counter
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = c_h_vis,
    parameter int H_FP   = c_h_fp,
    parameter int H_SYNC = c_h_sync,
    parameter int H_BP   = c_h_bp,
    parameter int V_VIS  = c_v_vis,
    parameter int V_FP   = c_v_fp,
    parameter int V_SYNC = c_v_sync,
    parameter int V_BP   = c_v_bp
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       exp_h,
    output logic       exp_v
);

    localparam logic [9:0] c_x_last  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_y_last  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_y_entry = 10'(V_VIS + V_FP);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_nx;
    logic [9:0] w_ny;

    // Position one tick ahead, wrapping at end of line and end of frame
    always_comb begin
        w_nx = r_x + 10'd1;
        w_ny = r_y;
        if (r_x == c_x_last) begin
            w_nx = '0;
            w_ny = (r_y == c_y_last) ? '0 : r_y + 10'd1;
        end
    end

    assign next_x = w_nx;
    assign next_y = w_ny;
    assign exp_h  = in_window(w_nx, H_VIS + H_FP, H_SYNC);
    assign exp_v  = in_window(w_ny, V_VIS + V_FP, V_SYNC);

    // Load the vsync-edge position, otherwise step when asked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (load) begin
            r_x <= '0;
            r_y <= c_y_entry;
        end else if (advance) begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rx_decoder
//  Description : Locks onto an incoming VGA sync stream, verifies it every
//                pixel tick, and emits decoded visible pixels with a per-frame
//                colour checksum.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_rx_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VIS   = c_h_vis,
    parameter int H_FP    = c_h_fp,
    parameter int H_SYNC  = c_h_sync,
    parameter int H_BP    = c_h_bp,
    parameter int V_VIS   = c_v_vis,
    parameter int V_FP    = c_v_fp,
    parameter int V_SYNC  = c_v_sync,
    parameter int V_BP    = c_v_bp,
    parameter int RGB_LAG = c_rgb_lag
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        h_synch,
    input  logic        v_synch,
    input  logic [2:0]  rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_sum,
    output logic        sum_valid
);

    localparam logic [9:0] c_y_entry   = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_x_vis     = 10'(H_VIS);
    localparam logic [9:0] c_y_vis     = 10'(V_VIS);
    localparam logic [9:0] c_x_vis_end = 10'(H_VIS - 1);
    localparam logic [9:0] c_y_vis_end = 10'(V_VIS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_v_prev;
    logic       w_load;
    logic       w_adv;
    logic       w_mismatch;
    logic       w_leave;
    logic       w_shift;
    logic       w_emit;
    logic [9:0] w_nx;
    logic [9:0] w_ny;
    logic       w_exp_h;
    logic       w_exp_v;
    pos_tap_t   w_cur;
    pos_tap_t   w_tap;

    logic        r_pix_valid;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic [2:0]  r_pix_rgb;
    logic        r_frame_start;
    logic        r_sync_err;
    logic [7:0]  r_err_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_frame_sum;
    logic        r_sum_pend;
    logic        r_sum_valid;

    vga_pos_counter #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .advance (w_adv),
        .next_x  (w_nx),
        .next_y  (w_ny),
        .exp_h   (w_exp_h),
        .exp_v   (w_exp_v)
    );

    // State register and previous vsync sample, both frozen between ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= SEARCH;
            r_v_prev <= 1'b0;
        end else if (pixel_tick) begin
            r_state  <= w_state_nxt;
            r_v_prev <= v_synch;
        end
    end

    // Next-state: hunt for a vsync edge, then check sync levels every tick
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_mismatch  = 1'b0;
        if (pixel_tick) begin
            case (r_state)
                SEARCH: begin
                    if (v_synch && !r_v_prev) begin
                        w_load      = 1'b1;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY, LOCKED: begin
                    w_adv = 1'b1;
                    if ((h_synch != w_exp_h) || (v_synch != w_exp_v)) begin
                        w_mismatch  = 1'b1;
                        w_state_nxt = SEARCH;
                    end else if ((r_state == VERIFY) && (w_nx == 10'd0) && (w_ny == c_y_entry)) begin
                        w_state_nxt = LOCKED;
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    assign w_leave = (r_state == LOCKED) && pixel_tick && (w_state_nxt != LOCKED);
    assign w_shift = pixel_tick && (r_state == LOCKED) && !w_mismatch;
    assign w_cur   = '{x: w_nx, y: w_ny, vis: (w_nx < c_x_vis) && (w_ny < c_y_vis)};

    generate
        if (RGB_LAG == 0) begin : g_no_lag
            assign w_tap = w_cur;
        end else begin : g_lag
            pos_tap_t [RGB_LAG-1:0] r_dl;

            // Coordinate delay line aligning positions with the lagging rgb
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dl <= '0;
                end else if (w_leave) begin
                    r_dl <= '0;
                end else if (w_shift) begin
                    r_dl[0] <= w_cur;
                    for (int i = 1; i < RGB_LAG; i++) begin
                        r_dl[i] <= r_dl[i-1];
                    end
                end
            end

            assign w_tap = r_dl[RGB_LAG-1];
        end
    endgenerate

    assign w_emit = w_shift && w_tap.vis;

    // Pixel, error and checksum outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= '0;
            r_acc         <= '0;
            r_frame_sum   <= '0;
            r_sum_pend    <= 1'b0;
            r_sum_valid   <= 1'b0;
        end else begin
            r_pix_valid   <= w_emit;
            r_frame_start <= w_emit && (w_tap.x == 10'd0) && (w_tap.y == 10'd0);
            r_sync_err    <= w_mismatch;
            if (w_emit) begin
                r_pix_x   <= w_tap.x;
                r_pix_y   <= w_tap.y;
                r_pix_rgb <= rgb;
            end
            if (w_mismatch && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            // Pixel (0,0) restarts the sum so only whole locked frames complete
            if (w_emit) begin
                r_acc <= (((w_tap.x == 10'd0) && (w_tap.y == 10'd0)) ? 16'd0 : r_acc) + {13'd0, rgb};
            end else if (w_leave) begin
                r_acc <= '0;
            end
            // The sum is published one clk after the last visible pixel
            r_sum_pend  <= w_emit && (w_tap.x == c_x_vis_end) && (w_tap.y == c_y_vis_end);
            r_sum_valid <= r_sum_pend;
            if (r_sum_pend) begin
                r_frame_sum <= r_acc;
            end
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_rgb     = r_pix_rgb;
    assign locked      = (r_state == LOCKED);
    assign frame_start = r_frame_start;
    assign sync_err    = r_sync_err;
    assign err_cnt     = r_err_cnt;
    assign frame_sum   = r_frame_sum;
    assign sum_valid   = r_sum_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rx_decoder
//  Description : Self-checking bench for vga_rx_decoder using a reduced raster
//                and a position-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_rx_decoder;

    localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_VIS = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int LAG   = 1;
    localparam int LINE  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int LINES = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = LINE * LINES;
    localparam int ENTRY = (V_VIS + V_FP) * LINE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_tick = 1'b0;
    logic        h_synch = 1'b0;
    logic        v_synch = 1'b0;
    logic [2:0]  rgb = 3'd0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [2:0]  pix_rgb;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [7:0]  err_cnt;
    logic [15:0] frame_sum;
    logic        sum_valid;

    vga_rx_decoder #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .RGB_LAG (LAG)
    ) dut (
        .clk (clk), .reset (reset), .pixel_tick (pixel_tick),
        .h_synch (h_synch), .v_synch (v_synch), .rgb (rgb),
        .pix_valid (pix_valid), .pix_x (pix_x), .pix_y (pix_y), .pix_rgb (pix_rgb),
        .locked (locked), .frame_start (frame_start), .sync_err (sync_err),
        .err_cnt (err_cnt), .frame_sum (frame_sum), .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks  = 0;

    // Reference model: lock age since the vsync edge, expected outputs held
    bit          m_hunting;
    int          m_age;
    int          m_err;
    logic [15:0] m_acc;
    logic [15:0] m_fsum;
    bit          m_pend;
    logic        m_vprev;
    int          m_px, m_py;
    logic [2:0]  m_prgb;

    // Ideal source position
    int   gx = 0, gy = 0, gx_prev = 0;
    int   rgb_mode = 0;
    logic g_vlast = 1'b0;
    bit   g_vrise;

    task automatic model_reset();
        m_hunting = 1; m_age = 0; m_err = 0; m_acc = '0; m_fsum = '0;
        m_pend = 0; m_vprev = 1'b0; m_px = 0; m_py = 0; m_prgb = '0;
    endtask

    // Apply one clk of stimulus, advance the model, and score every output
    task automatic step(input bit tk, input logic h_in, input logic v_in, input logic [2:0] c_in);
        bit   e_valid, e_fs, e_err, e_sumv, e_locked;
        int   p, cx, cy;
        logic eh, ev;
        e_valid = 0; e_fs = 0; e_err = 0;
        pixel_tick = tk; h_synch = h_in; v_synch = v_in; rgb = c_in;
        e_sumv = m_pend;
        if (m_pend) m_fsum = m_acc;
        m_pend = 0;
        if (tk) begin
            if (m_hunting) begin
                if (v_in && !m_vprev) begin
                    m_hunting = 0;
                    m_age = 0;
                end
            end else begin
                m_age++;
                p  = (ENTRY + m_age) % FRAME;
                cx = p % LINE;
                cy = p / LINE;
                eh = (cx >= H_VIS + H_FP) && (cx < H_VIS + H_FP + H_SYNC);
                ev = (cy >= V_VIS + V_FP) && (cy < V_VIS + V_FP + V_SYNC);
                if (h_in !== eh || v_in !== ev) begin
                    e_err = 1;
                    m_hunting = 1;
                    if (m_err < 255) m_err++;
                end else if (m_age - LAG > FRAME) begin
                    p  = (ENTRY + m_age - LAG) % FRAME;
                    cx = p % LINE;
                    cy = p / LINE;
                    if (cx < H_VIS && cy < V_VIS) begin
                        e_valid = 1;
                        e_fs = (cx == 0 && cy == 0);
                        m_px = cx; m_py = cy; m_prgb = c_in;
                        m_acc = (e_fs ? 16'd0 : m_acc) + 16'(c_in);
                        if (cx == H_VIS - 1 && cy == V_VIS - 1) m_pend = 1;
                    end
                end
            end
            m_vprev = v_in;
        end
        e_locked = !m_hunting && (m_age >= FRAME);
        @(posedge clk);
        #1;
        if (tk) n_ticks++;
        n_checks += 10;
        if (pix_valid !== e_valid) begin n_errors++; $display("FAIL pix_valid tick=%0d got=%0b want=%0b", n_ticks, pix_valid, e_valid); end
        if (frame_start !== e_fs) begin n_errors++; $display("FAIL frame_start tick=%0d got=%0b want=%0b", n_ticks, frame_start, e_fs); end
        if (sync_err !== e_err) begin n_errors++; $display("FAIL sync_err tick=%0d got=%0b want=%0b", n_ticks, sync_err, e_err); end
        if (locked !== e_locked) begin n_errors++; $display("FAIL locked tick=%0d got=%0b want=%0b", n_ticks, locked, e_locked); end
        if (sum_valid !== e_sumv) begin n_errors++; $display("FAIL sum_valid tick=%0d got=%0b want=%0b", n_ticks, sum_valid, e_sumv); end
        if (err_cnt !== 8'(m_err)) begin n_errors++; $display("FAIL err_cnt tick=%0d got=%0d want=%0d", n_ticks, err_cnt, m_err); end
        if (frame_sum !== m_fsum) begin n_errors++; $display("FAIL frame_sum tick=%0d got=%h want=%h", n_ticks, frame_sum, m_fsum); end
        if (pix_x !== 10'(m_px)) begin n_errors++; $display("FAIL pix_x tick=%0d got=%0d want=%0d", n_ticks, pix_x, m_px); end
        if (pix_y !== 10'(m_py)) begin n_errors++; $display("FAIL pix_y tick=%0d got=%0d want=%0d", n_ticks, pix_y, m_py); end
        if (pix_rgb !== m_prgb) begin n_errors++; $display("FAIL pix_rgb tick=%0d got=%0d want=%0d", n_ticks, pix_rgb, m_prgb); end
    endtask

    // One tick of the ideal source, optionally with a forced hsync glitch
    task automatic gen_tick(input bit force_h);
        logic       h, v;
        logic [2:0] c;
        h = ((gx >= H_VIS + H_FP) && (gx < H_VIS + H_FP + H_SYNC)) || force_h;
        v = (gy >= V_VIS + V_FP) && (gy < V_VIS + V_FP + V_SYNC);
        if (rgb_mode == 0)      c = 3'b110;
        else if (rgb_mode == 1) c = 3'(gx_prev);
        else                    c = 3'($urandom);
        g_vrise = v && !g_vlast;
        g_vlast = v;
        step(1'b1, h, v, c);
        gx_prev = gx;
        gx++;
        if (gx == LINE) begin
            gx = 0;
            gy = (gy + 1) % LINES;
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (pix_valid !== 1'b0 || pix_x !== 10'd0 || pix_y !== 10'd0 || pix_rgb !== 3'd0 ||
            locked !== 1'b0 || frame_start !== 1'b0 || sync_err !== 1'b0 ||
            err_cnt !== 8'd0 || frame_sum !== 16'd0 || sum_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s outputs got v=%0b x=%0d y=%0d rgb=%0d lk=%0b fs=%0b se=%0b ec=%0d sum=%h sv=%0b want all zero",
                     tag, pix_valid, pix_x, pix_y, pix_rgb, locked, frame_start, sync_err, err_cnt, frame_sum, sum_valid);
        end
    endtask

    // Run until locked, checking lock rises exactly one frame after the vsync edge
    task automatic wait_lock(input string tag);
        int t_edge;
        t_edge = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            gen_tick(1'b0);
            if (g_vrise && t_edge < 0) t_edge = n_ticks;
            if (locked) break;
        end
        n_checks++;
        if (locked !== 1'b1 || t_edge < 0 || (n_ticks - t_edge) != FRAME) begin
            n_errors++;
            $display("FAIL %s lock_time got locked=%0b delay=%0d want locked=1 delay=%0d", tag, locked, n_ticks - t_edge, FRAME);
        end
    endtask

    task automatic run_to(input int x, input int y);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (locked && gx == x && gy == y) break;
            gen_tick(1'b0);
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
    endtask

    task automatic test_lock_ideal();
        int n_pix;
        bit seen;
        rgb_mode = 0;
        gx = $urandom_range(0, LINE - 1);
        gy = $urandom_range(0, V_VIS + V_FP - 1);
        g_vlast = 1'b0;
        wait_lock("ideal");
        n_pix = 0;
        seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            gen_tick(1'b0);
            if (pix_valid) n_pix++;
            if (sum_valid) begin seen = 1; break; end
        end
        n_checks += 2;
        if (!seen || n_pix != H_VIS * V_VIS) begin
            n_errors++;
            $display("FAIL ideal_pixcount got=%0d sum_seen=%0b want=%0d", n_pix, seen, H_VIS * V_VIS);
        end
        if (frame_sum !== 16'(H_VIS * V_VIS * 6)) begin
            n_errors++;
            $display("FAIL ideal_sum got=%h want=%h", frame_sum, 16'(H_VIS * V_VIS * 6));
        end
    endtask

    task automatic test_rgb_lag();
        int n_pix;
        rgb_mode = 1;
        n_pix = 0;
        for (int i = 0; i < FRAME; i++) begin
            gen_tick(1'b0);
            if (pix_valid) begin
                n_pix++;
                n_checks++;
                if (pix_rgb !== pix_x[2:0]) begin
                    n_errors++;
                    $display("FAIL lag_rgb x=%0d got=%0d want=%0d", pix_x, pix_rgb, pix_x[2:0]);
                end
            end
        end
        n_checks++;
        if (n_pix != H_VIS * V_VIS) begin
            n_errors++;
            $display("FAIL lag_pixcount got=%0d want=%0d", n_pix, H_VIS * V_VIS);
        end
    endtask

    task automatic test_sync_glitch();
        int n_pix, n_serr;
        rgb_mode = 2;
        run_to(5, 2);
        gen_tick(1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch got se=%0b ec=%0d lk=%0b want se=1 ec=1 lk=0", sync_err, err_cnt, locked);
        end
        n_pix = 0;
        n_serr = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            gen_tick(1'b0);
            if (pix_valid) n_pix++;
            if (sync_err) n_serr++;
            if (locked) break;
        end
        n_checks++;
        if (locked !== 1'b1 || n_pix != 0 || n_serr != 0) begin
            n_errors++;
            $display("FAIL glitch_relock got lk=%0b pix=%0d errs=%0d want lk=1 pix=0 errs=0", locked, n_pix, n_serr);
        end
    endtask

    task automatic test_freeze();
        int n_pix, n_serr;
        logic h_r, v_r;
        logic [2:0] c_r;
        run_to(2, 3);
        for (int i = 0; i < 1000; i++) begin
            h_r = 1'($urandom); v_r = 1'($urandom); c_r = 3'($urandom);
            step(1'b0, h_r, v_r, c_r);
        end
        n_pix = 0;
        n_serr = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            gen_tick(1'b0);
            if (pix_valid) n_pix++;
            if (sync_err) n_serr++;
        end
        n_checks++;
        if (n_serr != 0 || n_pix != 2 * H_VIS * V_VIS || locked !== 1'b1 || err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL freeze_resume got errs=%0d pix=%0d lk=%0b ec=%0d want errs=0 pix=%0d lk=1 ec=1",
                     n_serr, n_pix, locked, err_cnt, 2 * H_VIS * V_VIS);
        end
    endtask

    task automatic test_reset_mid();
        run_to(4, 3);
        #2 reset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        pixel_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        wait_lock("reset_relock");
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_relock_errcnt got=%0d want=0", err_cnt);
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b0, 3'($urandom));
            step(1'b1, 1'b0, 1'b1, 3'($urandom));
            step(1'b1, 1'b1, 1'b1, 3'($urandom));
        end
        n_checks++;
        if (err_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL err_saturate got=%0d want=255", err_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_ideal();
        test_rgb_lag();
        test_sync_glitch();
        test_freeze();
        test_reset_mid();
        test_err_saturate();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
